// File: rtl/display_pkg.sv
// Shared display constants and types for the frame RAM read and write paths.
package display_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned TILE_DIM = 8;

  localparam logic [COLOUR_W-1:0] BG_COLOUR = 3'b000;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StDone
  } tile_state_e;

endpackage

// File: rtl/tile_pixel_counter.sv
// 6-bit pixel slot counter for one 8x8 tile; tc flags the last slot (63).
module tile_pixel_counter (
  input  logic       clock,
  input  logic       clear_b,
  input  logic       en,
  input  logic       clr,
  output logic [5:0] count,
  output logic       tc
);

  logic [5:0] count_q;

  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      count_q <= 6'd0;
    end else if (clr) begin
      count_q <= 6'd0;
    end else if (en) begin
      count_q <= count_q + 6'd1;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == 6'd63);

endmodule

// File: rtl/tile_ram_writer.sv
// Streams one 8x8 one-colour tile into the frame RAM, clipping off-screen pixels.
// Define TILE_TRANSPARENT_EN to skip writes for pattern-0 pixels (background preserved).
module tile_ram_writer #(
  parameter int unsigned SCREEN_W = display_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = display_pkg::SCREEN_H,
  parameter int unsigned ADDR_W   = display_pkg::ADDR_W
) (
  input  logic                             clock,
  input  logic                             clear_b,
  input  logic                             start,
  input  logic [7:0]                       x_in,
  input  logic [6:0]                       y_in,
  input  logic [display_pkg::COLOUR_W-1:0] colour,
  input  logic [63:0]                      pattern,
  output logic                             busy,
  output logic                             done,
  output logic [ADDR_W-1:0]                ram_addr,
  output logic [display_pkg::COLOUR_W-1:0] ram_data,
  output logic                             ram_wren
);

  import display_pkg::*;

  tile_state_e state_q, state_d;

  logic [7:0]          x_q;
  logic [6:0]          y_q;
  logic [COLOUR_W-1:0] colour_q;
  logic [63:0]         pattern_q;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COLOUR_W-1:0] data_q, data_d;

  logic       latch;
  logic       cnt_en, cnt_clr;
  logic [5:0] idx;
  logic       idx_tc;

  logic [2:0] col, row;
  logic [8:0] x_sum;
  logic [7:0] y_sum;
  logic       pix_on, on_screen;

  tile_pixel_counter u_counter (
    .clock   (clock),
    .clear_b (clear_b),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .count   (idx),
    .tc      (idx_tc)
  );

  // Sums kept one bit wider than the origin so off-screen pixels never wrap back on-screen.
  assign col       = idx[2:0];
  assign row       = idx[5:3];
  assign x_sum     = {1'b0, x_q} + {6'd0, col};
  assign y_sum     = {1'b0, y_q} + {5'd0, row};
  assign pix_on    = pattern_q[idx];
  assign on_screen = (x_sum < 9'(SCREEN_W)) && (y_sum < 8'(SCREEN_H));

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    wren_d  = 1'b0;
    addr_d  = '0;
    data_d  = BG_COLOUR;
    case (state_q)
      StIdle: begin
        if (start) begin
          latch   = 1'b1;
          cnt_clr = 1'b1;
          busy_d  = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        busy_d = 1'b1;
        cnt_en = 1'b1;
        addr_d = ADDR_W'(y_sum) * ADDR_W'(SCREEN_W) + ADDR_W'(x_sum);
        data_d = pix_on ? colour_q : BG_COLOUR;
`ifdef TILE_TRANSPARENT_EN
        wren_d = on_screen && pix_on;
`else
        wren_d = on_screen;
`endif
        if (idx_tc) begin
          state_d = StDone;
        end
      end
      StDone: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      pattern_q <= '0;
    end else if (latch) begin
      x_q       <= x_in;
      y_q       <= y_in;
      colour_q  <= colour;
      pattern_q <= pattern;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ram_wren = wren_q;
  assign ram_addr = addr_q;
  assign ram_data = data_q;

endmodule

// File: tb/tb_tile_ram_writer.sv
// Self-checking bench for tile_ram_writer: table of directed tiles, hand sequences, random tiles.
module tb_tile_ram_writer;

  logic        clock;
  logic        clear_b;
  logic        start;
  logic [7:0]  x_in;
  logic [6:0]  y_in;
  logic [2:0]  colour;
  logic [63:0] pattern;
  logic        busy;
  logic        done;
  logic [14:0] ram_addr;
  logic [2:0]  ram_data;
  logic        ram_wren;

  int vectors;
  int miscompares;

`ifdef TILE_TRANSPARENT_EN
  localparam bit Transp = 1'b1;
`else
  localparam bit Transp = 1'b0;
`endif

  tile_ram_writer dut (
    .clock    (clock),
    .clear_b  (clear_b),
    .start    (start),
    .x_in     (x_in),
    .y_in     (y_in),
    .colour   (colour),
    .pattern  (pattern),
    .busy     (busy),
    .done     (done),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_wren (ram_wren)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  bit       exp_wren [64];
  int       exp_addr [64];
  int       exp_data [64];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the tile in raster order and apply the clip/transparency rules directly.
  task automatic build_model(input int x, input int y, input int c, input logic [63:0] p);
    for (int r = 0; r < 8; r++) begin
      for (int cc = 0; cc < 8; cc++) begin
        int  px, py, s;
        bit  b;
        px = x + cc;
        py = y + r;
        s  = r * 8 + cc;
        b  = p[s];
        exp_wren[s] = (px < 160) && (py < 120) && (b || !Transp);
        exp_addr[s] = py * 160 + px;
        exp_data[s] = b ? c : 0;
      end
    end
  endtask

  task automatic run_tile(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                          input logic [63:0] p, input bit pre_started, input bit hold_start,
                          input int glitch_at, output int nwr, output int last_addr);
    build_model(int'(x), int'(y), int'(c), p);
    if (!pre_started) begin
      x_in = x; y_in = y; colour = c; pattern = p;
      start = 1'b1;
      @(posedge clock); #1;
    end
    start = hold_start;
    chk("busy_after_e0", int'(busy), 1);
    chk("done_after_e0", int'(done), 0);
    chk("wren_after_e0", int'(ram_wren), 0);
    nwr = 0;
    last_addr = -1;
    for (int k = 0; k < 64; k++) begin
      if (k == glitch_at) begin
        start = 1'b1;
        x_in = ~x; y_in = ~y; colour = ~c; pattern = ~p;
      end else if (glitch_at >= 0 && k == glitch_at + 1) begin
        start = hold_start;
      end
      @(posedge clock); #1;
      chk($sformatf("wren_slot%0d", k), int'(ram_wren), int'(exp_wren[k]));
      if (exp_wren[k]) begin
        chk($sformatf("addr_slot%0d", k), int'(ram_addr), exp_addr[k]);
        chk($sformatf("data_slot%0d", k), int'(ram_data), exp_data[k]);
      end
      chk($sformatf("busy_slot%0d", k), int'(busy), 1);
      chk($sformatf("done_slot%0d", k), int'(done), 0);
      if (ram_wren) begin
        nwr++;
        last_addr = int'(ram_addr);
      end
    end
    @(posedge clock); #1;
    chk("done_pulse", int'(done), 1);
    chk("busy_done_cycle", int'(busy), 1);
    chk("wren_done_cycle", int'(ram_wren), 0);
    @(posedge clock); #1;
    chk("done_cleared", int'(done), 0);
    chk("busy_after_tile", int'(busy), int'(hold_start));
  endtask

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
    logic [63:0] p;
    int          writes;
    int          last;
  } vec_t;

  initial begin
    vec_t tbl [4];
    int   nwr, last;

    tbl[0] = '{x: 8'd0,   y: 7'd0,   c: 3'b101, p: '1, writes: 64, last: 1127};
    tbl[1] = '{x: 8'd10,  y: 7'd5,   c: 3'b110, p: 64'hAA55AA55AA55AA55,
               writes: (Transp ? 32 : 64), last: 1937};
    tbl[2] = '{x: 8'd156, y: 7'd116, c: 3'b011, p: '1, writes: 16, last: 19199};
    tbl[3] = '{x: 8'd200, y: 7'd10,  c: 3'b111, p: '1, writes: 0, last: -1};

    vectors = 0;
    miscompares = 0;
    clear_b = 1'b0;
    start = 1'b0;
    x_in = '0; y_in = '0; colour = '0; pattern = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wren", int'(ram_wren), 0);
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_data", int'(ram_data), 0);
    @(negedge clock);
    clear_b = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 4; i++) begin
      run_tile(tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].p, 1'b0, 1'b0, -1, nwr, last);
      chk($sformatf("tbl%0d_writes", i), nwr, tbl[i].writes);
      if (tbl[i].writes > 0) chk($sformatf("tbl%0d_last_addr", i), last, tbl[i].last);
    end

    // Start pulse at E30 with scrambled inputs must be ignored.
    run_tile(8'd40, 7'd60, 3'b010, 64'h0123456789ABCDEF, 1'b0, 1'b0, 29, nwr, last);
    repeat (5) begin
      @(posedge clock); #1;
      chk("no_second_tile_busy", int'(busy), 0);
    end

    // Back-to-back: start held high, second tile accepted at E66.
    run_tile(8'd100, 7'd100, 3'b001, 64'hF0F0F0F00F0F0F0F, 1'b0, 1'b1, -1, nwr, last);
    run_tile(8'd100, 7'd100, 3'b001, 64'hF0F0F0F00F0F0F0F, 1'b1, 1'b0, -1, nwr, last);

    // Reset in the middle of a tile.
    x_in = 8'd30; y_in = 7'd40; colour = 3'b100; pattern = '1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (21) @(posedge clock);
    #1;
    chk("pre_abort_wren", int'(ram_wren), 1);
    clear_b = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_wren", int'(ram_wren), 0);
    chk("abort_addr", int'(ram_addr), 0);
    chk("abort_data", int'(ram_data), 0);
    @(negedge clock);
    clear_b = 1'b1;
    repeat (10) begin
      @(posedge clock); #1;
      chk("post_abort_wren", int'(ram_wren), 0);
      chk("post_abort_busy", int'(busy), 0);
    end
    run_tile(8'd0, 7'd0, 3'b101, '1, 1'b0, 1'b0, -1, nwr, last);
    chk("post_abort_writes", nwr, 64);

    for (int i = 0; i < 6; i++) begin
      logic [7:0]  rx;
      logic [6:0]  ry;
      logic [2:0]  rc;
      logic [63:0] rp;
      rx = 8'($urandom_range(0, 255));
      ry = 7'($urandom_range(0, 127));
      rc = 3'($urandom);
      rp = {$urandom, $urandom};
      run_tile(rx, ry, rc, rp, 1'b0, 1'b0, -1, nwr, last);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
